// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: TDM receive bundle; master drives in_valid/in_sof/in_data, slave drives out_a..out_d/out_valid/slot/frame_err
interface tdm_demux4_if #(parameter int WIDTH = 4);
  logic in_valid;
  logic in_sof;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;
  logic out_valid;
  logic [1:0] slot;
  logic frame_err;
  modport master (
    output in_valid, in_sof, in_data,
    input out_a, out_b, out_c, out_d, out_valid, slot, frame_err
  );
  modport slave (
    input in_valid, in_sof, in_data,
    output out_a, out_b, out_c, out_d, out_valid, slot, frame_err
  );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: 4:1 TDM receiver (clk, sync active-high reset, bus.slave: beat in -> registered frame out_a..out_d, out_valid, slot, frame_err)
module tdm_demux4 #(
  parameter int WIDTH = 4
) (
  input logic clk,
  input logic reset,
  tdm_demux4_if.slave bus
);
  typedef enum logic {IDLE, RECV} state_t;
  state_t state, state_n;
  logic [1:0] slot, slot_n;
  logic [WIDTH-1:0] sa, sb, sc, sa_n, sb_n, sc_n;
  logic [WIDTH-1:0] oa, ob, oc, od, oa_n, ob_n, oc_n, od_n;
  logic ov, ov_n, err, err_n;
  logic take_sof, take_data, done;
  always_comb begin
    take_sof = bus.in_valid && bus.in_sof;
    take_data = bus.in_valid && !bus.in_sof && state == RECV;
    done = take_data && slot == 2'd3;
    state_n = take_sof ? RECV : done ? IDLE : state;
    slot_n = take_sof ? 2'd1 : done ? 2'd0 : take_data ? slot + 2'd1 : slot;
    sa_n = take_sof ? bus.in_data : sa;
    sb_n = (take_data && slot == 2'd1) ? bus.in_data : sb;
    sc_n = (take_data && slot == 2'd2) ? bus.in_data : sc;
    oa_n = done ? sa : oa;
    ob_n = done ? sb : ob;
    oc_n = done ? sc : oc;
    od_n = done ? bus.in_data : od;
    ov_n = done;
    err_n = take_sof && state == RECV;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      slot <= '0;
      sa <= '0;
      sb <= '0;
      sc <= '0;
      oa <= '0;
      ob <= '0;
      oc <= '0;
      od <= '0;
      ov <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      slot <= slot_n;
      sa <= sa_n;
      sb <= sb_n;
      sc <= sc_n;
      oa <= oa_n;
      ob <= ob_n;
      oc <= oc_n;
      od <= od_n;
      ov <= ov_n;
      err <= err_n;
    end
  end
  assign bus.out_a = oa;
  assign bus.out_b = ob;
  assign bus.out_c = oc;
  assign bus.out_d = od;
  assign bus.out_valid = ov;
  assign bus.slot = slot;
  assign bus.frame_err = err;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: directed self-checking bench for tdm_demux4 with WIDTH=4
module tb_tdm_demux4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int passed = 0;
  int nv = 0;
  int ne = 0;
  int cyc = 0;
  int first_v = 0;
  tdm_demux4_if #(.WIDTH(4)) bus ();
  tdm_demux4 #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step(input logic r, input logic v, input logic s, input logic [3:0] d);
    @(negedge clk);
    reset = r;
    bus.in_valid = v;
    bus.in_sof = s;
    bus.in_data = d;
    @(posedge clk);
    #1;
    cyc++;
    if (bus.out_valid === 1'b1) begin
      nv++;
      if (nv == 1) first_v = cyc;
    end
    if (bus.frame_err === 1'b1) ne++;
  endtask
  function automatic logic [15:0] outs();
    return {bus.out_a, bus.out_b, bus.out_c, bus.out_d};
  endfunction
  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.in_data = '0;
    step(1, 1, 1, 4'h7);
    chk("rst_outs", 32'(outs()), 32'h0000);
    chk("rst_slot", 32'(bus.slot), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    nv = 0; ne = 0;
    step(0, 1, 1, 4'h1);
    chk("basic_slot1", 32'(bus.slot), 32'd1);
    step(0, 1, 0, 4'h2);
    chk("basic_slot2", 32'(bus.slot), 32'd2);
    step(0, 1, 0, 4'h3);
    chk("basic_slot3", 32'(bus.slot), 32'd3);
    chk("basic_partial_hidden", 32'(outs()), 32'h0000);
    chk("basic_no_valid_yet", 32'(bus.out_valid), 32'd0);
    step(0, 1, 0, 4'h4);
    chk("basic_outs", 32'(outs()), 32'h1234);
    chk("basic_valid", 32'(bus.out_valid), 32'd1);
    chk("basic_slot_wrap", 32'(bus.slot), 32'd0);
    step(0, 0, 0, 4'h0);
    chk("basic_valid_one_cycle", 32'(bus.out_valid), 32'd0);
    chk("basic_hold", 32'(outs()), 32'h1234);
    step(1, 0, 0, 4'h0);
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 1, i == 0, 4'(i + 1));
      if (i < 3) begin
        step(0, 0, 1, 4'hF);
        step(0, 0, 0, 4'hE);
      end
    end
    chk("gap_outs", 32'(outs()), 32'h1234);
    chk("gap_valid_now", 32'(bus.out_valid), 32'd1);
    chk("gap_pulse_count", 32'(nv), 32'd1);
    ne = 0; nv = 0;
    step(0, 1, 1, 4'hA);
    step(0, 1, 0, 4'hB);
    step(0, 1, 1, 4'h5);
    chk("esof_err", 32'(bus.frame_err), 32'd1);
    chk("esof_slot", 32'(bus.slot), 32'd1);
    chk("esof_hold", 32'(outs()), 32'h1234);
    step(0, 1, 0, 4'h6);
    chk("esof_err_one_cycle", 32'(bus.frame_err), 32'd0);
    step(0, 1, 0, 4'h7);
    step(0, 1, 0, 4'h8);
    chk("esof_outs", 32'(outs()), 32'h5678);
    chk("esof_err_count", 32'(ne), 32'd1);
    chk("esof_valid_count", 32'(nv), 32'd1);
    ne = 0;
    step(0, 1, 0, 4'h9);
    step(0, 1, 0, 4'h9);
    chk("stray_slot", 32'(bus.slot), 32'd0);
    chk("stray_hold", 32'(outs()), 32'h5678);
    step(0, 1, 1, 4'hF);
    step(0, 1, 0, 4'hE);
    step(0, 1, 0, 4'hD);
    step(0, 1, 0, 4'hC);
    chk("stray_outs", 32'(outs()), 32'hFEDC);
    chk("stray_no_err", 32'(ne), 32'd0);
    step(0, 1, 1, 4'h3);
    step(0, 0, 1, 4'h9);
    chk("invalid_sof_slot", 32'(bus.slot), 32'd1);
    chk("invalid_sof_no_err", 32'(bus.frame_err), 32'd0);
    step(0, 1, 0, 4'h4);
    step(0, 1, 0, 4'h5);
    step(0, 1, 0, 4'h6);
    chk("invalid_sof_outs", 32'(outs()), 32'h3456);
    ne = 0;
    step(0, 1, 1, 4'h9);
    step(0, 1, 0, 4'h9);
    step(1, 1, 0, 4'h7);
    chk("midrst_outs", 32'(outs()), 32'h0000);
    chk("midrst_slot", 32'(bus.slot), 32'd0);
    step(0, 1, 1, 4'h1);
    step(0, 1, 0, 4'h2);
    step(0, 1, 0, 4'h3);
    chk("midrst_partial_hidden", 32'(outs()), 32'h0000);
    step(0, 1, 0, 4'h4);
    chk("midrst_outs_done", 32'(outs()), 32'h1234);
    chk("midrst_no_err", 32'(ne), 32'd0);
    nv = 0; cyc = 0; first_v = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, i % 4 == 0, 4'(i + 1));
      if (i == 3) chk("b2b_first_outs", 32'(outs()), 32'h1234);
    end
    chk("b2b_second_outs", 32'(outs()), 32'h5678);
    chk("b2b_pulse_count", 32'(nv), 32'd2);
    chk("b2b_first_pulse_cycle", 32'(first_v), 32'd4);
    chk("b2b_second_pulse_now", 32'(bus.out_valid), 32'd1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/tdm_demux4.md
TDM_DEMUX4 -- requirements
Module: tdm_demux4

Interface
REQ-001 Parameter WIDTH, default 4, sets the bit width of each data channel.
REQ-002 clk  input  1  single clock for the whole block; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_valid  input  1  in_data/in_sof carry a valid beat this cycle.
REQ-005 in_sof  input  1  start of frame; marks the beat as slot 0 (channel a); qualified by in_valid.
REQ-006 in_data  input  WIDTH  serialized channel data, one channel per valid beat, order a,b,c,d.
REQ-007 out_a  output  WIDTH  channel a of the last complete frame, registered.
REQ-008 out_b  output  WIDTH  channel b of the last complete frame, registered.
REQ-009 out_c  output  WIDTH  channel c of the last complete frame, registered.
REQ-010 out_d  output  WIDTH  channel d of the last complete frame, registered.
REQ-011 out_valid  output  1  one-cycle pulse: out_a..out_d were just updated with a new frame.
REQ-012 slot  output  2  index of the next expected slot (00=a, 01=b, 10=c, 11=d), registered.
REQ-013 frame_err  output  1  one-cycle pulse: the current frame was aborted by an early in_sof.

Function
REQ-014 The block SHALL be the receive end of a 4:1 time-division link: it demultiplexes a beat stream into four parallel channels.
REQ-015 FSM states SHALL be IDLE (waiting for in_sof) and RECV (collecting slots 1..3).
REQ-016 IDLE, in_valid=1, in_sof=1: the block SHALL store in_data into the slot-a staging register, set slot=01, and go to RECV.
REQ-017 IDLE, in_valid=1, in_sof=0: the block SHALL discard the beat, stay in IDLE with slot=00, and leave frame_err low.
REQ-018 RECV, in_valid=1, in_sof=0, slot<11: the block SHALL store in_data into the staging register indexed by slot and increment slot.
REQ-019 RECV, in_valid=1, in_sof=0, slot=11: on that edge the block SHALL load out_a..out_c from staging and out_d from in_data, all at once, set slot=00, and go to IDLE.
REQ-020 out_valid SHALL be high for exactly the one cycle following the edge of REQ-019, so latency is 1 cycle from the slot-d beat to visible outputs.
REQ-021 RECV, in_valid=1, in_sof=1: the block SHALL pulse frame_err for one cycle, discard the partial frame, store in_data as slot a, set slot=01, and stay in RECV.
REQ-022 in_valid=0 in any state: state, slot, staging and outputs SHALL hold, and in_sof SHALL be ignored.
REQ-023 out_a..out_d SHALL change only on a completed frame; partial frames SHALL never be visible on the outputs.
REQ-024 Back-to-back frames (slot-d beat immediately followed by an in_sof beat) SHALL be accepted without a gap cycle; the in_sof beat is processed in IDLE on the next edge.
REQ-025 slot wrap: after slot-d the block SHALL return to 00, never incrementing past 11.
REQ-026 Data SHALL be passed through bit-exact with no arithmetic; all widths SHALL equal WIDTH.

Reset
REQ-027 On reset=1 at a rising edge the block SHALL enter IDLE with slot=00, out_a..out_d=0, staging=0, out_valid=0 and frame_err=0.
REQ-028 Reset SHALL take priority over any in_valid beat in the same cycle; that beat is lost.
REQ-029 Reset during RECV SHALL discard the partial frame without a frame_err pulse.

Verification
REQ-030 Basic frame, WIDTH=4: reset; beats (sof=1,1), (0,2), (0,3), (0,4) on consecutive cycles -> one cycle later out_a..d=1,2,3,4, out_valid high for one cycle, slot=00.
REQ-031 Gaps: the same frame with in_valid=0 for 2 cycles between each beat -> identical outputs; out_valid pulses once only, after the 4th beat.
REQ-032 Early sof: beats (1,A),(0,B),(1,5),(0,6),(0,7),(0,8) -> frame_err pulses after the 3rd beat; outputs then become 5,6,7,8 with a single out_valid pulse.
REQ-033 Stray data: beats (0,9),(0,9) in IDLE, then a valid frame F,E,D,C -> no error pulse, outputs F,E,D,C.
REQ-034 Reset mid-frame: after 2 beats of a frame assert reset for 1 cycle, then send frame 1,2,3,4 -> outputs read 0 until the frame completes, then 1,2,3,4; frame_err is never asserted.
REQ-035 Back-to-back: two frames (1,2,3,4) and (5,6,7,8) with no idle cycles -> out_valid pulses twice, 4 cycles apart, and outputs follow each frame.
